// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button sync/debounce, 1 Hz prescaler, counter strobes and display mode.
// Latency: button level to state/strobe change is DEBOUNCE_CYCLES+3 clocks; strobes are registered.
// Backpressure: none; buttons and switches are sampled every cycle and strobes are single-cycle pulses.
module stopwatch_ctrl #(
    parameter int CNT_W           = 13,
    parameter int TICK_DIV        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_clear,
    input  logic [7:0]       sw,
    input  logic             cnt_at_max,
    output logic             cnt_inc,
    output logic             cnt_clr,
    output logic             cnt_load,
    output logic [CNT_W-1:0] load_val,
    output logic [1:0]       state,
    output logic             running,
    output logic             ovf,
    output logic             blink
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_PAUSE  = 2'b10;
    localparam logic [1:0] S_ADJUST = 2'b11;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV);

    // Index 0 is the start/stop button, index 1 is the clear button.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [1:0]    press;
    logic [DW-1:0] dcnt [2];

    logic [PW-1:0] presc;
    logic          wrap;
    logic          press_clr;
    logic          press_start;

    assign wrap        = (presc == PW'(TICK_DIV - 1));
    assign press_clr   = press[1];
    // Clear wins over start when both arrive in the same cycle.
    assign press_start = press[0] & ~press[1];
    assign running     = (state == S_RUN);

    // Synchronise raw buttons, accept a new level after a full run of differing samples, emit rising-edge press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= {btn_clear, btn_start};
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb & ~deb_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]  <= sync2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + DW'(1);
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    // Mode sequencing, prescaler, overflow/blink flags and registered counter strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            presc    <= '0;
            ovf      <= 1'b0;
            blink    <= 1'b0;
            cnt_inc  <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_load <= 1'b0;
            load_val <= '0;
        end else begin
            cnt_inc  <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (press_clr) begin
                        cnt_clr <= 1'b1;
                    end else if (press_start) begin
                        state <= S_RUN;
                        presc <= '0;
                    end else if (sw[7]) begin
                        state <= S_ADJUST;
                        presc <= '0;
                    end
                end
                S_RUN: begin
                    if (press_clr) begin
                        cnt_clr <= 1'b1;
                        ovf     <= 1'b0;
                        presc   <= '0;
                    end else if (press_start) begin
                        // Prescaler keeps its phase so resume continues the partial second.
                        state <= S_PAUSE;
                    end else if (wrap) begin
                        presc <= '0;
                        if (cnt_at_max) begin
                            ovf   <= 1'b1;
                            state <= S_PAUSE;
                        end else begin
                            cnt_inc <= 1'b1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (press_clr) begin
                        cnt_clr <= 1'b1;
                        ovf     <= 1'b0;
                        presc   <= '0;
                        state   <= S_IDLE;
                    end else if (press_start && !ovf) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    if (press_clr) begin
                        cnt_clr <= 1'b1;
                    end else if (press_start) begin
                        cnt_load <= 1'b1;
                        load_val <= CNT_W'(sw[6:0]);
                    end
                    // Leaving adjust still honours a press taken in the same cycle (handled above).
                    if (!sw[7]) begin
                        state <= S_IDLE;
                        blink <= 1'b0;
                        presc <= '0;
                    end else if (wrap) begin
                        presc <= '0;
                        blink <= ~blink;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed vector table, async reset check and random run against a reference model.
// Latency: model predicts outputs after each rising edge; DUT sampled on the falling edge.
// Backpressure: not applicable; inputs change on falling edges only.
module tb_stopwatch_ctrl;

    localparam int CW = 13;
    localparam int TD = 10;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_start = 1'b0;
    logic          btn_clear = 1'b0;
    logic [7:0]    sw = 8'h00;
    logic          cnt_at_max = 1'b0;
    logic          cnt_inc;
    logic          cnt_clr;
    logic          cnt_load;
    logic [CW-1:0] load_val;
    logic [1:0]    state;
    logic          running;
    logic          ovf;
    logic          blink;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CNT_W(CW), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear), .sw(sw),
        .cnt_at_max(cnt_at_max), .cnt_inc(cnt_inc), .cnt_clr(cnt_clr), .cnt_load(cnt_load),
        .load_val(load_val), .state(state), .running(running), .ovf(ovf), .blink(blink)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Buttons: a raw sample taken at edge n reaches the debouncer at edge n+2; the
    // debounced level flips after DB consecutive differing samples, and a rise at
    // edge r is acted upon by the mode logic at edge r+2.
    logic [1:0]    m_state;
    int            m_presc;
    bit            m_ovf, m_blink, m_inc, m_clr, m_load;
    logic [CW-1:0] m_lv;
    int            m_n;
    bit            hist [2][4];
    bit            lvl [2];
    int            streak [2];
    int            rose_at [2];
    bit            m_b [2];
    bit            m_pr [2];
    bit            m_smp, pc, ps;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_state = 2'd0; m_presc = 0; m_ovf = 0; m_blink = 0;
            m_inc = 0; m_clr = 0; m_load = 0; m_lv = '0; m_n = 0;
            for (int i = 0; i < 2; i++) begin
                lvl[i] = 0; streak[i] = 0; rose_at[i] = -100;
                for (int j = 0; j < 4; j++) hist[i][j] = 0;
            end
        end else begin
            m_b[0] = btn_start;
            m_b[1] = btn_clear;
            for (int i = 0; i < 2; i++) begin
                m_pr[i] = (rose_at[i] == m_n - 2);
                hist[i][m_n % 4] = m_b[i];
                m_smp = (m_n >= 2) ? hist[i][(m_n - 2) % 4] : 1'b0;
                if (m_smp != lvl[i]) begin
                    streak[i]++;
                    if (streak[i] == DB) begin
                        lvl[i] = m_smp;
                        streak[i] = 0;
                        if (m_smp) rose_at[i] = m_n;
                    end
                end else begin
                    streak[i] = 0;
                end
            end
            pc = m_pr[1];
            ps = m_pr[0] && !m_pr[1];
            m_inc = 0; m_clr = 0; m_load = 0;
            case (m_state)
                2'd0: begin
                    if (pc) m_clr = 1;
                    else if (ps) begin m_state = 2'd1; m_presc = 0; end
                    else if (sw[7]) begin m_state = 2'd3; m_presc = 0; end
                end
                2'd1: begin
                    if (pc) begin m_clr = 1; m_ovf = 0; m_presc = 0; end
                    else if (ps) m_state = 2'd2;
                    else if (m_presc == TD - 1) begin
                        m_presc = 0;
                        if (cnt_at_max) begin m_ovf = 1; m_state = 2'd2; end
                        else m_inc = 1;
                    end else m_presc++;
                end
                2'd2: begin
                    if (pc) begin m_clr = 1; m_ovf = 0; m_presc = 0; m_state = 2'd0; end
                    else if (ps && !m_ovf) m_state = 2'd1;
                end
                default: begin
                    if (pc) m_clr = 1;
                    else if (ps) begin m_load = 1; m_lv = CW'(sw & 8'h7f); end
                    if (!sw[7]) begin m_state = 2'd0; m_blink = 0; m_presc = 0; end
                    else if (m_presc == TD - 1) begin m_presc = 0; m_blink = !m_blink; end
                    else m_presc++;
                end
            endcase
            m_n++;
        end
    end

    // Per-cycle comparison of every output against the model.
    logic [20:0] act_v, exp_v;
    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            act_v = {state, running, ovf, blink, cnt_inc, cnt_clr, cnt_load, load_val};
            exp_v = {m_state, (m_state == 2'd1), m_ovf, m_blink, m_inc, m_clr, m_load, m_lv};
            chk($sformatf("model t=%0t", $time), int'(act_v), int'(exp_v));
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       st;
        bit       cl;
        bit [7:0] sw;
        bit       mx;
        int       cyc;
        int       e_state;
        int       e_ovf;
        int       e_blink;
        int       e_inc;
        int       e_clr;
        int       e_load;
        int       e_first;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit st, input bit cl, input bit [7:0] s, input bit mx, input int cyc,
                       input int es, input int eo, input int eb, input int ei, input int ec,
                       input int el, input int ef);
        vec_t v;
        v.st = st; v.cl = cl; v.sw = s; v.mx = mx; v.cyc = cyc;
        v.e_state = es; v.e_ovf = eo; v.e_blink = eb;
        v.e_inc = ei; v.e_clr = ec; v.e_load = el; v.e_first = ef;
        tbl.push_back(v);
    endtask

    int n_inc, n_clr, n_load, first, lv_seen, strobes;
    int hs, hc, hw, hm;

    initial begin
        //   st cl sw     mx cyc  state ovf blk inc clr ld first
        add(0, 0, 8'h00, 0, 100, 0, 0, 0, 0, 0, 0, -1);  // idle, no strobes
        add(1, 0, 8'h00, 0, 20,  1, 0, 0, 1, 0, 0, 18);  // start held: RUN at 8, inc 10 later
        add(0, 0, 8'h00, 0, 27,  1, 0, 0, 2, 0, 0, 8);   // 10-cycle cadence
        add(1, 0, 8'h00, 0, 20,  2, 0, 0, 1, 0, 0, 1);   // pause with prescaler=6
        add(0, 0, 8'h00, 0, 50,  2, 0, 0, 0, 0, 0, -1);  // paused: no inc
        add(1, 0, 8'h00, 0, 14,  1, 0, 0, 1, 0, 0, 12);  // resume: inc 4 after RUN
        add(0, 0, 8'h00, 0, 26,  1, 0, 0, 2, 0, 0, 8);
        add(1, 0, 8'h00, 0, 1,   1, 0, 0, 0, 0, 0, -1);  // 1-cycle glitch
        add(0, 0, 8'h00, 0, 3,   1, 0, 0, 1, 0, 0, 1);
        add(1, 0, 8'h00, 0, 2,   1, 0, 0, 0, 0, 0, -1);  // 2-cycle glitch
        add(0, 0, 8'h00, 0, 3,   1, 0, 0, 0, 0, 0, -1);
        add(1, 0, 8'h00, 0, 3,   1, 0, 0, 1, 0, 0, 3);   // 3-cycle glitch
        add(0, 0, 8'h00, 0, 3,   1, 0, 0, 0, 0, 0, -1);
        add(1, 1, 8'h00, 0, 12,  1, 0, 0, 1, 1, 0, 7);   // start+clear: clear wins
        add(0, 0, 8'h00, 0, 10,  1, 0, 0, 1, 0, 0, 6);
        add(0, 0, 8'h00, 1, 10,  2, 1, 0, 0, 0, 0, -1);  // overflow at wrap
        add(1, 0, 8'h00, 0, 12,  2, 1, 0, 0, 0, 0, -1);  // start ignored while ovf
        add(0, 0, 8'h00, 0, 8,   2, 1, 0, 0, 0, 0, -1);
        add(0, 1, 8'h00, 0, 12,  0, 0, 0, 0, 1, 0, -1);  // clear: ovf=0, IDLE
        add(0, 0, 8'h00, 0, 8,   0, 0, 0, 0, 0, 0, -1);
        add(0, 0, 8'h85, 0, 20,  3, 0, 1, 0, 0, 0, -1);  // adjust, blink toggles at wrap
        add(1, 0, 8'h85, 0, 12,  3, 0, 1, 0, 0, 1, -1);  // single load of 5
        add(0, 0, 8'h85, 0, 8,   3, 0, 1, 0, 0, 0, -1);
        add(0, 0, 8'h05, 0, 5,   0, 0, 0, 0, 0, 0, -1);  // leave adjust, blink=0

        // Reset state before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("reset outputs", int'({state, running, ovf, blink, cnt_inc, cnt_clr, cnt_load, load_val}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        foreach (tbl[k]) begin
            btn_start = tbl[k].st; btn_clear = tbl[k].cl; sw = tbl[k].sw; cnt_at_max = tbl[k].mx;
            n_inc = 0; n_clr = 0; n_load = 0; first = -1; lv_seen = -1;
            for (int c = 1; c <= tbl[k].cyc; c++) begin
                @(negedge clk);
                if (cnt_inc) begin n_inc++; if (first < 0) first = c; end
                if (cnt_clr) n_clr++;
                if (cnt_load) begin n_load++; lv_seen = int'(load_val); end
            end
            chk($sformatf("v%0d state", k), int'(state), tbl[k].e_state);
            chk($sformatf("v%0d ovf", k), int'(ovf), tbl[k].e_ovf);
            chk($sformatf("v%0d blink", k), int'(blink), tbl[k].e_blink);
            chk($sformatf("v%0d inc_count", k), n_inc, tbl[k].e_inc);
            chk($sformatf("v%0d clr_count", k), n_clr, tbl[k].e_clr);
            chk($sformatf("v%0d load_count", k), n_load, tbl[k].e_load);
            chk($sformatf("v%0d first_inc", k), first, tbl[k].e_first);
            if (tbl[k].e_load > 0)
                chk($sformatf("v%0d load_val", k), lv_seen, int'(tbl[k].sw & 8'h7f));
        end

        // Asynchronous reset in the middle of RUN.
        btn_start = 1'b1; btn_clear = 1'b0; sw = 8'h00; cnt_at_max = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre-reset running", int'(running), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        btn_start = 1'b0;
        #1;
        chk("async reset state", int'(state), 0);
        chk("async reset outputs", int'({running, ovf, blink, cnt_inc, cnt_clr, cnt_load, load_val}), 0);
        @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            strobes += int'(cnt_inc) + int'(cnt_clr) + int'(cnt_load);
        end
        chk("post-reset idle strobes", strobes, 0);

        // Random stimulus, checked every cycle against the model.
        hs = 0; hc = 0; hw = 0; hm = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hs == 0) begin
                btn_start = !btn_start;
                hs = btn_start ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 16));
            end else hs--;
            if (hc == 0) begin
                btn_clear = !btn_clear;
                hc = btn_clear ? int'($urandom_range(1, 10)) : int'($urandom_range(10, 60));
            end else hc--;
            if (hw == 0) begin
                sw = 8'($urandom);
                hw = int'($urandom_range(10, 80));
            end else hw--;
            if (hm == 0) begin
                cnt_at_max = ($urandom_range(0, 3) == 0);
                hm = int'($urandom_range(1, 30));
            end else hm--;
        end
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
